axis_pipe_slice: RTL and testbench

AXIS_PIPE_SLICE -- requirements
Module: axis_pipe_slice

---
 rtl/axis_pipe_slice.sv | 148 ++++++++++++++
 tb/tb_axis_pipe_slice.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pipe_slice.sv
// Chain of AXI-Stream register slices. REG_MODE 0 adds a skid register to each stage so
// that every ready is registered. REG_MODE 1 registers only the forward path.
module axis_pipe_slice #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 2,
  parameter int STAGES     = 2,
  parameter int REG_MODE   = 0,
  parameter int OCC_WD     = $clog2(2 * STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [KEEP_WIDTH-1:0] keep_in,
  input  logic [USER_WIDTH-1:0] user_in,
  input  logic                  last_in,
  output logic                  ready_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [KEEP_WIDTH-1:0] keep_out,
  output logic [USER_WIDTH-1:0] user_out,
  output logic                  last_out,
  input  logic                  ready_in,
  output logic [OCC_WD-1:0]     occupancy
);

  localparam int W = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

  // Handshake: a beat moves across any link on the rising edge where valid && ready are
  // both high. A valid beat holds its payload until taken; ready may change at any time.
  logic         s_valid [STAGES+1];
  logic         s_ready [STAGES+1];
  logic [W-1:0] s_word  [STAGES+1];

  assign s_valid[0]      = valid_in;
  assign s_word[0]       = {data_in, keep_in, user_in, last_in};
  assign s_ready[STAGES] = ready_in;
  assign ready_out       = s_ready[0];
  assign valid_out       = s_valid[STAGES];
  assign {data_out, keep_out, user_out, last_out} = s_word[STAGES];

  genvar i;
  generate
    for (i = 0; i < STAGES; i++) begin : g_stage
      logic         main_valid;
      logic [W-1:0] main_word;
      logic         in_acc;
      logic         main_drain;

      assign in_acc       = s_valid[i] && s_ready[i];
      assign main_drain   = main_valid && s_ready[i+1];
      assign s_valid[i+1] = main_valid;
      assign s_word[i+1]  = main_word;

      if (REG_MODE == 0) begin : g_skid
        logic         skid_valid;
        logic         skid_valid_nxt;
        logic [W-1:0] skid_word;
        logic         rdy_q;

        always_comb begin
          skid_valid_nxt = skid_valid;
          if (flush) begin
            skid_valid_nxt = 1'b0;
          end else if (skid_valid && (!main_valid || main_drain)) begin
            skid_valid_nxt = 1'b0;
          end else if (in_acc && main_valid && !main_drain) begin
            skid_valid_nxt = 1'b1;
          end
        end

        // Ready is a flop tracking the next skid state, so ready_in never reaches ready_out
        always_ff @(posedge clk) begin
          if (rst) begin
            main_valid <= 1'b0;
            main_word  <= '0;
            skid_valid <= 1'b0;
            skid_word  <= '0;
            rdy_q      <= 1'b0;
          end else begin
            skid_valid <= skid_valid_nxt;
            rdy_q      <= !skid_valid_nxt;
            if (flush) begin
              main_valid <= 1'b0;
            end else if (skid_valid && (!main_valid || main_drain)) begin
              main_valid <= 1'b1;
              main_word  <= skid_word;
            end else if (in_acc && (!main_valid || main_drain)) begin
              main_valid <= 1'b1;
              main_word  <= s_word[i];
            end else if (main_drain) begin
              main_valid <= 1'b0;
            end
            if (!flush && in_acc && main_valid && !main_drain) begin
              skid_word <= s_word[i];
            end
          end
        end

        assign s_ready[i] = rdy_q;
      end else begin : g_fwd
        logic init_q;

        always_ff @(posedge clk) begin
          if (rst) begin
            init_q     <= 1'b0;
            main_valid <= 1'b0;
            main_word  <= '0;
          end else begin
            init_q <= 1'b1;
            if (flush) begin
              main_valid <= 1'b0;
            end else if (in_acc) begin
              main_valid <= 1'b1;
              main_word  <= s_word[i];
            end else if (main_drain) begin
              main_valid <= 1'b0;
            end
          end
        end

        // init_q keeps ready low while reset is held
        assign s_ready[i] = init_q && (s_ready[i+1] || !main_valid);
      end
    end
  endgenerate

  logic             acc;
  logic             del;
  logic [OCC_WD-1:0] occ_q;

  assign acc       = valid_in && ready_out;
  assign del       = valid_out && ready_in;
  assign occupancy = occ_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else if (acc && !del) begin
      occ_q <= occ_q + OCC_WD'(1);
    end else if (!acc && del) begin
      occ_q <= occ_q - OCC_WD'(1);
    end
  end

endmodule

// File: tb/tb_axis_pipe_slice.sv
// Bench for axis_pipe_slice: a 2-stage skid chain checked against a scoreboard every
// cycle, plus a 3-stage forward-registered chain.
module tb_axis_pipe_slice;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 2;
  localparam int W  = DW + KW + UW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [KW-1:0] keep_in = '0;
  logic [UW-1:0] user_in = '0;
  logic          last_in = 1'b0;
  logic          ready_out;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [KW-1:0] keep_out;
  logic [UW-1:0] user_out;
  logic          last_out;
  logic          ready_in = 1'b0;
  logic [2:0]    occupancy;

  logic          m1_valid_in = 1'b0;
  logic [DW-1:0] m1_data_in = '0;
  logic          m1_ready_out;
  logic          m1_valid_out;
  logic [DW-1:0] m1_data_out;
  logic [KW-1:0] m1_keep_out;
  logic [UW-1:0] m1_user_out;
  logic          m1_last_out;
  logic          m1_ready_in = 1'b0;
  logic [2:0]    m1_occupancy;

  axis_pipe_slice #(.DATA_WIDTH(DW), .STAGES(2), .REG_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .user_in(user_in),
    .last_in(last_in), .ready_out(ready_out),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .user_out(user_out),
    .last_out(last_out), .ready_in(ready_in), .occupancy(occupancy)
  );

  axis_pipe_slice #(.DATA_WIDTH(DW), .STAGES(3), .REG_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .valid_in(m1_valid_in), .data_in(m1_data_in), .keep_in(4'hf), .user_in(2'b01),
    .last_in(1'b0), .ready_out(m1_ready_out),
    .valid_out(m1_valid_out), .data_out(m1_data_out), .keep_out(m1_keep_out),
    .user_out(m1_user_out), .last_out(m1_last_out), .ready_in(m1_ready_in),
    .occupancy(m1_occupancy)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_out = 0;
  int occ_model = 0;
  int first_acc = -1;
  int first_out = -1;
  int last_out_cyc = -1;
  bit mon_en = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: accepted beats are queued, delivered beats are popped and compared
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (occupancy !== 3'(occ_model))
        $display("FAIL occupancy_model cyc %0d: got %0d expected %0d", cyc, occupancy, occ_model);
      else n_pass++;
      if (valid_out && ready_in) begin
        n_out++;
        last_out_cyc = cyc;
        if (first_out < 0) first_out = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_beat cyc %0d: got %0h expected no beat", cyc,
                   {data_out, keep_out, user_out, last_out});
        end else begin
          exp_w = exp_q.pop_front();
          if ({data_out, keep_out, user_out, last_out} !== exp_w)
            $display("FAIL beat_order cyc %0d: got %0h expected %0h", cyc,
                     {data_out, keep_out, user_out, last_out}, exp_w);
          else n_pass++;
        end
      end
      if (valid_in && ready_out) begin
        exp_q.push_back({data_in, keep_in, user_in, last_in});
        if (first_acc < 0) first_acc = cyc;
      end
      occ_model = occ_model + int'(valid_in && ready_out) - int'(valid_out && ready_in);
      if (rst || flush) begin
        exp_q.delete();
        occ_model = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_beat(input logic [W-1:0] w);
    int t;
    logic hs;
    bit done;
    t = 0;
    done = 1'b0;
    valid_in = 1'b1;
    {data_in, keep_in, user_in, last_in} = w;
    while (!done) begin
      @(negedge clk);
      hs = ready_out;
      @(posedge clk);
      #1;
      t++;
      if (hs) done = 1'b1;
      else if (t > 100) begin
        n_checks++;
        $display("FAIL drive_timeout: got no accept expected accept within 100 cycles");
        done = 1'b1;
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (valid_out !== 1'b0) $display("FAIL rst_valid: got %b expected 0", valid_out); else n_pass++;
    n_checks++; if (ready_out !== 1'b0) $display("FAIL rst_ready: got %b expected 0", ready_out); else n_pass++;
    n_checks++; if (occupancy !== 3'd0) $display("FAIL rst_occ: got %0d expected 0", occupancy); else n_pass++;
    n_checks++; if (data_out !== 32'h0) $display("FAIL rst_data: got %0h expected 0", data_out); else n_pass++;
    n_checks++; if (m1_ready_out !== 1'b0) $display("FAIL rst_m1_ready: got %b expected 0", m1_ready_out); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ready_out !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", ready_out); else n_pass++;
    n_checks++; if (m1_ready_out !== 1'b1) $display("FAIL rst_release_m1_ready: got %b expected 1", m1_ready_out); else n_pass++;
    occ_model = 0;
    mon_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int base;
    base = n_out;
    ready_in = 1'b1;
    first_acc = -1;
    first_out = -1;
    for (int i = 1; i <= 8; i++) begin
      drive_beat({32'(i), 4'hf, 2'(i), i == 8});
      if (i == 4) begin
        n_checks++; if (occupancy !== 3'd2) $display("FAIL stream_occ: got %0d expected 2", occupancy); else n_pass++;
      end
    end
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (first_out - first_acc !== 2) $display("FAIL stream_latency: got %0d expected 2", first_out - first_acc); else n_pass++;
    n_checks++; if (last_out_cyc - first_out !== 7) $display("FAIL stream_throughput: got %0d expected 7", last_out_cyc - first_out); else n_pass++;
    n_checks++; if (n_out - base !== 8) $display("FAIL stream_count: got %0d expected 8", n_out - base); else n_pass++;
  endtask

  task automatic test_stall();
    int acc;
    int base;
    logic hs;
    acc = 0;
    ready_in = 1'b0;
    valid_in = 1'b1;
    {data_in, keep_in, user_in, last_in} = {32'h100, 4'h3, 2'd2, 1'b0};
    repeat (10) begin
      @(negedge clk);
      hs = ready_out;
      @(posedge clk); #1;
      if (hs) begin
        acc++;
        data_in = 32'h100 + 32'(acc);
      end
    end
    valid_in = 1'b0;
    n_checks++; if (acc !== 4) $display("FAIL stall_accepts: got %0d expected 4", acc); else n_pass++;
    n_checks++; if (ready_out !== 1'b0) $display("FAIL stall_ready: got %b expected 0", ready_out); else n_pass++;
    n_checks++; if (occupancy !== 3'd4) $display("FAIL stall_occ: got %0d expected 4", occupancy); else n_pass++;
    n_checks++; if (data_out !== 32'h100) $display("FAIL stall_hold: got %0h expected 100", data_out); else n_pass++;
    base = n_out;
    ready_in = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_checks++; if (n_out - base !== 4) $display("FAIL stall_drain: got %0d expected 4", n_out - base); else n_pass++;
    n_checks++; if (ready_out !== 1'b1) $display("FAIL stall_ready_back: got %b expected 1", ready_out); else n_pass++;
  endtask

  task automatic test_flush();
    int base;
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) drive_beat({32'h200 + 32'(i), 4'hf, 2'd1, 1'b0});
    n_checks++; if (occupancy !== 3'd3) $display("FAIL flush_pre_occ: got %0d expected 3", occupancy); else n_pass++;
    valid_in = 1'b1;
    {data_in, keep_in, user_in, last_in} = {32'hdead, 4'hf, 2'd3, 1'b1};
    flush = 1'b1;
    @(negedge clk);
    n_checks++; if (ready_out !== 1'b1) $display("FAIL flush_ready: got %b expected 1", ready_out); else n_pass++;
    @(posedge clk); #1;
    flush = 1'b0;
    valid_in = 1'b0;
    n_checks++; if (valid_out !== 1'b0) $display("FAIL flush_valid: got %b expected 0", valid_out); else n_pass++;
    n_checks++; if (occupancy !== 3'd0) $display("FAIL flush_occ: got %0d expected 0", occupancy); else n_pass++;
    n_checks++; if (ready_out !== 1'b1) $display("FAIL flush_ready_after: got %b expected 1", ready_out); else n_pass++;
    base = n_out;
    ready_in = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (n_out !== base) $display("FAIL flush_ghost: got %0d beats expected 0", n_out - base); else n_pass++;
  endtask

  task automatic test_rst_mid();
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) drive_beat({32'h300 + 32'(i), 4'h1, 2'd0, 1'b0});
    n_checks++; if (occupancy !== 3'd4) $display("FAIL rstmid_pre_occ: got %0d expected 4", occupancy); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (valid_out !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", valid_out); else n_pass++;
    n_checks++; if (ready_out !== 1'b0) $display("FAIL rstmid_ready: got %b expected 0", ready_out); else n_pass++;
    n_checks++; if (occupancy !== 3'd0) $display("FAIL rstmid_occ: got %0d expected 0", occupancy); else n_pass++;
    n_checks++; if (data_out !== 32'h0) $display("FAIL rstmid_data: got %0h expected 0", data_out); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ready_out !== 1'b1) $display("FAIL rstmid_ready_back: got %b expected 1", ready_out); else n_pass++;
    ready_in = 1'b1;
    first_acc = -1;
    first_out = -1;
    drive_beat({32'h3aa, 4'h5, 2'd1, 1'b1});
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (first_out - first_acc !== 2) $display("FAIL rstmid_latency: got %0d expected 2", first_out - first_acc); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL rstmid_left: got %0d expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    int sent;
    int cycles;
    int base;
    logic hs;
    sent = 0;
    cycles = 0;
    base = n_out;
    valid_in = 1'b0;
    while (sent < 1000 && cycles < 20000) begin
      ready_in = 1'($urandom_range(0, 1));
      if (!valid_in) begin
        valid_in = 1'($urandom_range(0, 1));
        data_in = $urandom;
        keep_in = 4'($urandom_range(0, 15));
        user_in = 2'($urandom_range(0, 3));
        last_in = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      hs = valid_in && ready_out;
      @(posedge clk); #1;
      cycles++;
      if (hs) begin
        sent++;
        valid_in = 1'b0;
      end
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (sent !== 1000) $display("FAIL random_sent: got %0d expected 1000", sent); else n_pass++;
    n_checks++; if (n_out - base !== 1000) $display("FAIL random_recv: got %0d expected 1000", n_out - base); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL random_left: got %0d expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_fwd_mode();
    int acc;
    logic hs;
    acc = 0;
    m1_ready_in = 1'b0;
    m1_valid_in = 1'b1;
    m1_data_in = 32'h10;
    repeat (8) begin
      @(negedge clk);
      hs = m1_ready_out;
      @(posedge clk); #1;
      if (hs) begin
        acc++;
        m1_data_in = 32'h10 + 32'(acc);
      end
    end
    m1_valid_in = 1'b0;
    n_checks++; if (acc !== 3) $display("FAIL fwd_accepts: got %0d expected 3", acc); else n_pass++;
    n_checks++; if (m1_occupancy !== 3'd3) $display("FAIL fwd_occ: got %0d expected 3", m1_occupancy); else n_pass++;
    n_checks++; if (m1_ready_out !== 1'b0) $display("FAIL fwd_ready_full: got %b expected 0", m1_ready_out); else n_pass++;
    m1_ready_in = 1'b1;
    #1;
    n_checks++; if (m1_ready_out !== 1'b1) $display("FAIL fwd_ready_comb: got %b expected 1", m1_ready_out); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (!(m1_valid_out === 1'b1 && m1_data_out === 32'h10 + 32'(k)))
        $display("FAIL fwd_order %0d: got v=%b %0h expected v=1 %0h", k, m1_valid_out, m1_data_out, 32'h10 + 32'(k));
      else n_pass++;
    end
    @(posedge clk); #1;
    m1_ready_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_rst_mid();
    test_random();
    test_fwd_mode();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
